// File: rtl/tt_page_loader.sv
// tt_page_loader: copies one teletext page from parallel flash into the
// VGA teletext RAM one byte at a time through its tt_address/tt_data/tt_write port.
//
// Ports:
//   clk1x, nrst           clock, async active-low reset
//   start, page_req       one-cycle load request and its page number
//   auto_advance          enables the dwell-timer page stepping
//   flash_address/data    flash read port {2'b0, page, offset}
//   tt_address/data/write display RAM write port
//   busy, done, cur_page  copy status and page most recently selected

module tt_page_loader #(
  parameter int unsigned FLASH_WAIT = 3,
  parameter int unsigned PAGE_BYTES = 1000,
  parameter int unsigned PAGE_COUNT = 486,
  parameter int unsigned DWELL      = 32'h4000000
) (
  input  logic        clk1x,
  input  logic        nrst,
  input  logic        start,
  input  logic [8:0]  page_req,
  input  logic        auto_advance,
  output logic [20:0] flash_address,
  input  logic [7:0]  flash_data,
  output logic [9:0]  tt_address,
  output logic [7:0]  tt_data,
  output logic        tt_write,
  output logic        busy,
  output logic        done,
  output logic [8:0]  cur_page
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WRITE,
    FINISH
  } state_t;

  state_t      state;
  state_t      state_d;

  logic [9:0]  offset;
  logic [15:0] wcnt;
  logic [31:0] dcnt;
  logic        boot;
  logic        pend_v;
  logic [8:0]  pend_page;

  logic        load;
  logic [8:0]  load_page;
  logic [8:0]  req_ok;
  logic [8:0]  next_page;
  logic        wait_end;
  logic        last_byte;
  logic        dwell_end;
  logic        copying;

  // Out-of-range requests fall back to page 0.
  assign req_ok = (32'(page_req) >= PAGE_COUNT) ? 9'd0 : page_req;

  assign next_page = (32'(cur_page) >= PAGE_COUNT - 1) ?
                     9'd0 : cur_page + 9'd1;

  assign wait_end  = (wcnt == 16'(FLASH_WAIT - 1));
  assign last_byte = (offset == 10'(PAGE_BYTES - 1));
  assign dwell_end = auto_advance && (dcnt == 32'(DWELL - 1));
  assign copying   = (state == FETCH) || (state == WRITE);

  assign flash_address = {2'b00, cur_page, offset};

  always_ff @(posedge clk1x or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    load_page = cur_page;
    busy      = 1'b0;
    done      = 1'b0;
    tt_write  = 1'b0;
    unique case (state)
      IDLE: begin
        // start beats the boot load and dwell expiry
        if (start) begin
          load      = 1'b1;
          load_page = req_ok;
        end else if (boot) begin
          load      = 1'b1;
          load_page = 9'd0;
        end else if (dwell_end) begin
          load      = 1'b1;
          load_page = next_page;
        end
      end
      FETCH: begin
        busy = 1'b1;
        if (wait_end) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy     = 1'b1;
        tt_write = 1'b1;
        state_d  = last_byte ? FINISH : FETCH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
        // a start here is newer than anything pending
        if (start) begin
          load      = 1'b1;
          load_page = req_ok;
        end else if (pend_v) begin
          load      = 1'b1;
          load_page = pend_page;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk1x or negedge nrst) begin
    if (!nrst) begin
      cur_page   <= 9'd0;
      offset     <= 10'd0;
      wcnt       <= 16'd0;
      dcnt       <= 32'd0;
      boot       <= 1'b1;
      pend_v     <= 1'b0;
      pend_page  <= 9'd0;
      tt_address <= 10'd0;
      tt_data    <= 8'd0;
    end else begin
      if (load) begin
        cur_page <= load_page;
        offset   <= 10'd0;
        wcnt     <= 16'd0;
        pend_v   <= 1'b0;
        boot     <= 1'b0;
      end else begin
        if (start && copying) begin
          pend_v    <= 1'b1;
          pend_page <= req_ok;
        end
        if (state == FETCH) begin
          if (wait_end) begin
            wcnt       <= 16'd0;
            tt_data    <= flash_data;
            tt_address <= offset;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        if (state == WRITE && !last_byte) begin
          offset <= offset + 10'd1;
        end
      end
      if (load || state != IDLE || !auto_advance) begin
        dcnt <= 32'd0;
      end else begin
        dcnt <= dcnt + 32'd1;
      end
    end
  end

endmodule
